// File: rtl/renkon_serial_drain.sv
// renkon_serial_drain: bank-major read sequencer for the serial output memory matrix.
// Walks core_num banks of out_size words each, absorbs the matrix read latency, and
// streams results as a valid/ready beat stream.
// Optional: define RENKON_DRAIN_RELU_EN to clamp negative read data to zero on FIFO write.
module renkon_serial_drain #(
    parameter int DWIDTH     = 16,
    parameter int OUTSIZE    = 12,
    parameter int CORELOG    = 3,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      xrst,
    input  logic                      start,
    input  logic [OUTSIZE-1:0]        out_size,
    input  logic [CORELOG:0]          core_num,
    output logic [CORELOG:0]          serial_re,
    output logic [OUTSIZE-1:0]        serial_addr,
    input  logic signed [DWIDTH-1:0]  serial_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DWIDTH-1:0]         m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CORELOG:0] NBANK = (CORELOG+1)'(1 << CORELOG);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH, S_DONE} state_t;

    state_t                r_state;
    logic [OUTSIZE-1:0]    r_size;
    logic [CORELOG:0]      r_cores;
    logic [CORELOG:0]      r_bank;
    logic [OUTSIZE-1:0]    r_addr;
    logic [CORELOG:0]      r_re;
    logic [OUTSIZE-1:0]    r_saddr;
    logic                  r_busy;
    logic                  r_done;
    logic [READ_LAT-1:0]   r_v;
    logic [READ_LAT-1:0]   r_l;
    logic [DWIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_ml;
    logic [CW-1:0]         r_cnt;
    logic                  r_mval;

    logic [CW-1:0]         w_infl;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_last_rd;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_cnt_nxt;
    logic [AW-1:0]         w_widx;
    logic [CORELOG:0]      w_cores;
    logic [DWIDTH-1:0]     w_din;

    // Reads in flight: one bit per outstanding read in the latency pipe.
    always_comb begin
        w_infl = '0;
        for (int i = 0; i < READ_LAT; i++) w_infl = w_infl + CW'(r_v[i]);
    end

    assign w_credit  = ({1'b0, r_cnt} + {1'b0, w_infl}) < (CW+1)'(FIFO_DEPTH);
    assign w_issue   = (r_state == S_ISSUE) && w_credit;
    assign w_last_rd = (r_bank == r_cores - 1'b1) && (r_addr == r_size - 1'b1);
    assign w_push    = r_v[READ_LAT-1];
    assign w_pop     = r_mval && m_ready;
    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_widx    = AW'(w_pop ? r_cnt - 1'b1 : r_cnt);
    assign w_cores   = (core_num > NBANK) ? NBANK : core_num;

`ifdef RENKON_DRAIN_RELU_EN
    assign w_din = serial_data[DWIDTH-1] ? '0 : serial_data;
`else
    assign w_din = serial_data;
`endif

    // Sequencer: latches the job, walks banks bank-major under FIFO credit, then flushes.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state <= S_IDLE;
            r_size  <= '0;
            r_cores <= '0;
            r_bank  <= '0;
            r_addr  <= '0;
            r_re    <= '0;
            r_saddr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_re   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_size  <= out_size;
                        r_cores <= w_cores;
                        r_bank  <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= (out_size == '0 || core_num == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_re    <= r_bank + 1'b1;
                        r_saddr <= r_addr;
                        if (r_addr == r_size - 1'b1) begin
                            r_addr <= '0;
                            r_bank <= r_bank + 1'b1;
                            if (w_last_rd) r_state <= S_FLUSH;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_infl == '0 && r_cnt == '0) r_state <= S_DONE;
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Latency pipe: tracks each issued read and its last tag until the data returns.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_v <= '0;
            r_l <= '0;
        end else begin
            r_v <= (r_v << 1) | READ_LAT'(w_issue);
            r_l <= (r_l << 1) | READ_LAT'(w_issue && w_last_rd);
        end
    end

    // Shifting output FIFO: head lives in entry 0 so m_data/m_last come straight from registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_ml   <= '0;
            r_cnt  <= '0;
            r_mval <= 1'b0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
                r_mem[FIFO_DEPTH-1] <= '0;
                r_ml <= r_ml >> 1;
            end
            if (w_push) begin
                r_mem[w_widx] <= w_din;
                r_ml[w_widx]  <= r_l[READ_LAT-1];
            end
            r_cnt  <= w_cnt_nxt;
            r_mval <= w_cnt_nxt != '0;
        end
    end

    // Credit accounting must make a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!xrst)
        !(w_push && !w_pop && r_cnt == CW'(FIFO_DEPTH)));

    assign serial_re   = r_re;
    assign serial_addr = r_saddr;
    assign m_valid     = r_mval;
    assign m_data      = r_mem[0];
    assign m_last      = r_ml[0];
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/renkon_serial_drain.md
Name: renkon_serial_drain

Overview:
- Read-side sequencer for the renkon serial output memory matrix (8 banks, bank k selected by serial_re = k+1).
- Once a layer has finished writing, it walks the used banks bank-major, issues serial_re/serial_addr, and absorbs the fixed matrix read latency.
- Returns results as a valid/ready beat stream toward the ninjin DRAM writeback path, with full backpressure support.

Parameters:
DWIDTH, 16, data word width (signed)
OUTSIZE, 12, serial memory address width
CORELOG, 3, log2 of bank count; serial_re is CORELOG+1 bits
READ_LAT, 2, cycles from presenting serial_re/serial_addr to valid serial_data (1 memory + 1 output mux register)
FIFO_DEPTH, 4, output buffer depth; must be >= READ_LAT+1, power of two

Ports:
clk  in  1  clock
xrst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a drain when idle
out_size  in  OUTSIZE  words per bank; sampled at start
core_num  in  CORELOG+1  number of banks to drain; sampled at start
serial_re  out  CORELOG+1  bank select to matrix (bank+1 while reading, 0 otherwise)
serial_addr  out  OUTSIZE  word address to matrix
serial_data  in  DWIDTH  read data returned from matrix
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  DWIDTH  output beat data
m_last  out  1  marks final beat of the drain
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async, xrst=0): state IDLE; serial_re=0, serial_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0; FIFO emptied; in-flight pipe cleared. Reset mid-drain aborts immediately and emits no done.
- All outputs are registered.
- States:
  - IDLE: on start, latch out_size and core_num; clamp core_num to 2^CORELOG. If either is 0, go to DONE; otherwise go to ISSUE with bank=0, addr=0.
  - ISSUE: issue one read per cycle when fifo_count + inflight < FIFO_DEPTH. Issue means serial_re<=bank+1 and serial_addr<=addr. Advance addr; on addr==out_size-1, wrap addr to 0 and increment bank. After the last read (bank==core_num-1, addr==out_size-1), go to FLUSH. A non-issue cycle drives serial_re<=0.
  - FLUSH: serial_re=0; wait for inflight==0 and FIFO empty, including the accept of the last beat; then go to DONE.
  - DONE: done=1 for one cycle, busy=0; return to IDLE.
- Read timing:
  - A READ_LAT-deep valid shift register, tagged with a last flag, tracks issued reads.
  - serial_data is captured into the FIFO exactly READ_LAT cycles after issue.
  - inflight is the count of set bits in the shift register.
- Output stream:
  - m_valid = FIFO non-empty; a beat transfers on m_valid && m_ready.
  - m_data and m_last must hold stable while m_valid && !m_ready.
  - A FIFO push and pop in the same cycle leaves the count unchanged.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion error.
- Beat order: bank 0 addr 0..out_size-1, then bank 1, … up to bank core_num-1. Total beats = core_num*out_size. m_last is set only on the final beat.
- start while busy is ignored. out_size/core_num changes after start are ignored.
- out_size = 2^OUTSIZE is not representable; the maximum is 2^OUTSIZE-1 words.

Optional Feature:
- Macro RENKON_DRAIN_RELU_EN.
- Defined: data is clamped on FIFO write: negative serial_data becomes 0, non-negative values pass unchanged. No added latency.
- Undefined: data passes unmodified.

Test Plan:
- core_num=2, out_size=3, banks preloaded bank0={10,11,12}, bank1={20,21,22}, m_ready=1 -> serial_re sequence 1,1,1,2,2,2. Beats 10,11,12,20,21,22; m_last on the 6th beat only. done pulses once after the last accept; busy low in the same cycle as done.
- Same load, m_ready=0 for 12 cycles after start, then 1 -> at most 4 reads issued while stalled. m_data holds 10 stable throughout the stall. All 6 beats are delivered in order, none lost or duplicated.
- m_ready toggling 1,0,1,0… with core_num=8, out_size=5 -> exactly 40 beats in bank-major order; the FIFO never exceeds 4 entries.
- out_size=0 (or core_num=0) -> no beats, serial_re stays 0, done pulses 2 cycles after start.
- start pulsed again on the 3rd cycle of a drain -> ignored, single done. xrst asserted mid-drain -> all outputs 0 immediately, no done. A fresh start afterwards drains from bank0 addr0.
- With RENKON_DRAIN_RELU_EN defined, bank0={-5,0,7} -> beats 0,0,7. Without the macro -> beats -5,0,7.
